// File: rtl/exec_mul_sequencer.sv
// Sequential 64x64 shift-add multiplier for the execute stage.
// A mulq sitting in E starts a fixed ITER-cycle run while the front of the
// pipeline is held; the low 64 bits and {ZF,SF,OF} are published on completion.
module exec_mul_sequencer #(
  parameter logic [3:0] OPQ    = 4'h6,
  parameter logic [3:0] MULFUN = 4'h4,
  parameter int         ITER   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic        abort,
  output logic        mul_stall,
  output logic        mul_busy,
  output logic        mul_done,
  output logic [63:0] mul_valE,
  output logic [2:0]  mul_cf
);

  // Wide enough to hold ITER-1 for any ITER >= 1.
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg;
  logic [63:0]    acc_reg;
  logic [63:0]    mcand_reg;
  logic [63:0]    mplier_reg;

  logic           start;
  logic           last_iter;
  logic [63:0]    acc_sum;

  // An abort in M/W suppresses a start the same cycle it is seen.
  assign start     = (E_icode == OPQ) && (E_ifun == MULFUN) && !abort;
  assign last_iter = (count_reg == CW'(ITER - 1));
  // Accumulator after this cycle's add; bit-63 carry is simply dropped.
  assign acc_sum   = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs; abort beats the final iteration.
  always_comb begin
    state_next = state_reg;
    mul_stall  = 1'b0;
    mul_busy   = 1'b0;
    mul_done   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        mul_stall = start;
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        mul_stall = !abort;
        mul_busy  = 1'b1;
        if (abort) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Stall is released here so the pipeline advances past the mulq.
        mul_done   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Reset dominates: never hold the pipeline while rst_n is low.
    if (!rst_n) begin
      mul_stall = 1'b0;
      mul_busy  = 1'b0;
    end
  end

  // Datapath: operand load on start, one shift-add step per RUN cycle,
  // result and flags captured only on the RUN->DONE edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      mul_valE   <= '0;
      mul_cf     <= 3'b000;
    end else begin
      if (state_reg == IDLE && start) begin
        mcand_reg  <= E_valA;
        mplier_reg <= E_valB;
        acc_reg    <= '0;
        count_reg  <= '0;
      end else if (state_reg == RUN) begin
        acc_reg    <= acc_sum;
        mcand_reg  <= {mcand_reg[62:0], 1'b0};
        mplier_reg <= {1'b0, mplier_reg[63:1]};
        count_reg  <= count_reg + CW'(1);
      end
      if (state_reg == RUN && !abort && last_iter) begin
        mul_valE <= acc_sum;
        mul_cf   <= {(acc_sum == 64'd0), acc_sum[63], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Self-checking bench for exec_mul_sequencer: directed vector table,
// hand-written abort/reset/back-to-back sequences and randomized operands
// checked against a plain-arithmetic product model.
module tb_exec_mul_sequencer;

  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] MULFUN = 4'h4;
  localparam int         ITER   = 64;

  logic        clk;
  logic        rst_n;
  logic [3:0]  E_icode;
  logic [3:0]  E_ifun;
  logic [63:0] E_valA;
  logic [63:0] E_valB;
  logic        abort;
  logic        mul_stall;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_valE;
  logic [2:0]  mul_cf;

  exec_mul_sequencer #(.OPQ(OPQ), .MULFUN(MULFUN), .ITER(ITER)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .E_icode   (E_icode),
    .E_ifun    (E_ifun),
    .E_valA    (E_valA),
    .E_valB    (E_valB),
    .abort     (abort),
    .mul_stall (mul_stall),
    .mul_busy  (mul_busy),
    .mul_done  (mul_done),
    .mul_valE  (mul_valE),
    .mul_cf    (mul_cf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] last_val = '0;
  logic [2:0]  last_cf  = 3'b000;
  int          start_cyc;
  int          last_done_cyc;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_val;
    logic [2:0]  exp_cf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: the true product truncated to 64 bits, flags from that value.
  function automatic logic [63:0] ref_product(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] full;
    full = {64'd0, a} * {64'd0, b};
    return full[63:0];
  endfunction

  function automatic logic [2:0] ref_flags(input logic [63:0] p);
    return {(p == 64'd0), p[63], 1'b0};
  endfunction

  // Issue one mulq at the current cycle (called just after a rising edge).
  // abort_at < 0: run to completion; otherwise abort is pulsed in RUN cycle abort_at.
  task automatic do_mul(input logic [63:0] a, input logic [63:0] b, input int abort_at,
                        input logic [63:0] exp_val, input logic [2:0] exp_cf, input string nm);
    int          stall_bad = 0;
    int          busy_bad  = 0;
    int          done_at   = -1;
    int          done_cnt  = 0;
    int          last_c;
    logic [63:0] got_val   = '0;
    logic [2:0]  got_cf    = '0;
    last_c    = (abort_at < 0) ? ITER + 1 : ITER + 3;
    start_cyc = cyc;
    E_icode = OPQ; E_ifun = MULFUN; E_valA = a; E_valB = b;
    for (int c = 0; c <= last_c; c++) begin
      if (c == abort_at) begin
        abort = 1'b1; E_icode = 4'h0;
      end else if (c == abort_at + 1) begin
        abort = 1'b0;
      end
      @(negedge clk);
      if (abort_at < 0) begin
        if (c <= ITER && !mul_stall) stall_bad++;
        if (c >= 1 && c <= ITER && !mul_busy) busy_bad++;
        if (c == 0 && mul_busy) busy_bad++;
        if (c == ITER + 1 && (mul_stall || mul_busy)) stall_bad++;
      end else begin
        if (c < abort_at && !mul_stall) stall_bad++;
        if (c >= abort_at && mul_stall) stall_bad++;
        if (c > abort_at && mul_busy) busy_bad++;
      end
      if (mul_done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = c; got_val = mul_valE; got_cf = mul_cf; last_done_cyc = cyc;
        end
      end
      @(posedge clk); #1;
      // Operands after the load edge must not matter.
      if (c == 0) begin
        E_valA = {$urandom, $urandom}; E_valB = {$urandom, $urandom};
      end
    end
    E_icode = 4'h0; E_ifun = 4'h0;
    chk({nm, " stall"}, 64'(stall_bad), 64'd0);
    chk({nm, " busy"}, 64'(busy_bad), 64'd0);
    if (abort_at < 0) begin
      chk({nm, " done_cycle"}, 64'(done_at), 64'(ITER + 1));
      chk({nm, " valE"}, got_val, exp_val);
      chk({nm, " cf"}, 64'(got_cf), 64'(exp_cf));
      last_val = exp_val; last_cf = exp_cf;
    end else begin
      chk({nm, " no_done"}, 64'(done_cnt), 64'd0);
      chk({nm, " valE_held"}, mul_valE, exp_val);
      chk({nm, " cf_held"}, 64'(mul_cf), 64'(exp_cf));
    end
    $display("%s: a=%h b=%h abort_at=%0d done_at=%0d valE=%h cf=%b",
             nm, a, b, abort_at, done_at, mul_valE, mul_cf);
  endtask

  initial begin
    logic [63:0] ra, rb, rp;
    int          ab;
    int          d1;

    vecs[0] = '{64'd3, 64'd5, 64'd15, 3'b000};
    vecs[1] = '{64'd0, 64'h1234, 64'd0, 3'b100};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 3'b010};
    vecs[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 3'b100};
    vecs[5] = '{64'd7, 64'd0, 64'd0, 3'b100};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b000};

    // Reset with a mulq presented: nothing may stall or start.
    rst_n = 1'b0; abort = 1'b0;
    E_icode = OPQ; E_ifun = MULFUN; E_valA = 64'd9; E_valB = 64'd9;
    @(negedge clk);
    chk("reset stall", 64'(mul_stall), 64'd0);
    chk("reset busy", 64'(mul_busy), 64'd0);
    chk("reset done", 64'(mul_done), 64'd0);
    chk("reset valE", mul_valE, 64'd0);
    chk("reset cf", 64'(mul_cf), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; E_icode = 4'h0; E_ifun = 4'h0;
    @(negedge clk);
    chk("post_reset busy", 64'(mul_busy), 64'd0);
    $display("reset: stall=%b busy=%b valE=%h", mul_stall, mul_busy, mul_valE);

    // Non-mulq operations in IDLE never stall.
    @(posedge clk); #1;
    E_icode = OPQ; E_ifun = 4'h3;
    @(negedge clk);
    chk("addq stall", 64'(mul_stall), 64'd0);
    @(posedge clk); #1;
    E_icode = 4'h4; E_ifun = MULFUN;
    @(negedge clk);
    chk("rmmov stall", 64'(mul_stall), 64'd0);
    @(posedge clk); #1;
    chk("nonmul busy", 64'(mul_busy), 64'd0);
    $display("non-mulq: stall=%b busy=%b", mul_stall, mul_busy);
    E_icode = 4'h0; E_ifun = 4'h0;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      do_mul(vecs[i].a, vecs[i].b, -1, vecs[i].exp_val, vecs[i].exp_cf, $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Back-to-back mulq: second start in the cycle right after DONE.
    do_mul(64'd2, 64'd3, -1, 64'd6, 3'b000, "b2b_first");
    d1 = last_done_cyc;
    chk("b2b first latency", 64'(d1 - start_cyc), 64'(ITER + 1));
    do_mul(64'd4, 64'd5, -1, 64'd20, 3'b000, "b2b_second");
    chk("b2b spacing", 64'(last_done_cyc - d1), 64'(ITER + 2));
    @(posedge clk); #1;

    // Aborts: mid-run, and coinciding with the final iteration.
    do_mul(64'd9, 64'd9, 30, last_val, last_cf, "abort_mid");
    do_mul(64'd11, 64'd3, ITER, last_val, last_cf, "abort_last");

    // Reset in the middle of a run.
    E_icode = OPQ; E_ifun = MULFUN; E_valA = 64'd11; E_valB = 64'd13;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst stall", 64'(mul_stall), 64'd0);
    chk("midrst busy", 64'(mul_busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; E_icode = 4'h0; E_ifun = 4'h0;
    @(negedge clk);
    chk("midrst valE", mul_valE, 64'd0);
    chk("midrst cf", 64'(mul_cf), 64'd0);
    chk("midrst done", 64'(mul_done), 64'd0);
    $display("mid-run reset: valE=%h cf=%b done=%b", mul_valE, mul_cf, mul_done);
    last_val = '0; last_cf = 3'b000;
    @(posedge clk); #1;
    do_mul(64'd7, 64'd6, -1, 64'd42, 3'b000, "after_reset");

    // Randomized operands, occasionally aborted.
    for (int i = 0; i < 16; i++) begin
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ITER)) : -1;
      if (ab < 0) begin
        rp = ref_product(ra, rb);
        do_mul(ra, rb, -1, rp, ref_flags(rp), $sformatf("rand%0d", i));
      end else begin
        do_mul(ra, rb, ab, last_val, last_cf, $sformatf("rand%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_mul_sequencer.md
EXEC_MUL_SEQUENCER -- requirements
Module: exec_mul_sequencer

Interface
REQ-001 SHALL have parameter OPQ, default 4'h6, meaning the icode of arithmetic/logic operations.
REQ-002 SHALL have parameter MULFUN, default 4'h4, meaning the ifun selecting multiply (mulq).
REQ-003 SHALL have parameter ITER, default 64, meaning the number of shift-add iterations.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port E_icode  input  4  icode held in the execute pipeline register.
REQ-007 SHALL have port E_ifun  input  4  ifun held in the execute pipeline register.
REQ-008 SHALL have port E_valA  input  64  multiplicand.
REQ-009 SHALL have port E_valB  input  64  multiplier.
REQ-010 SHALL have port abort  input  1  exception in M or W stage; cancels the multiply in flight.
REQ-011 SHALL have port mul_stall  output  1  hold the F, D and E pipeline registers this cycle.
REQ-012 SHALL have port mul_busy  output  1  high in RUN.
REQ-013 SHALL have port mul_done  output  1  one-cycle pulse; result valid.
REQ-014 SHALL have port mul_valE  output  64  product, low 64 bits.
REQ-015 SHALL have port mul_cf  output  3  flags {ZF,SF,OF}, bit2 = ZF, bit1 = SF, bit0 = OF.

Function
REQ-016 start SHALL be (E_icode==OPQ) & (E_ifun==MULFUN) & ~abort.
REQ-017 FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE SHALL go to RUN on start and otherwise stay in IDLE.
REQ-019 RUN SHALL go to IDLE on abort, to DONE after the iteration with count==ITER-1, and otherwise stay in RUN.
REQ-020 DONE SHALL go to IDLE unconditionally and SHALL NOT evaluate start.
REQ-021 On the IDLE->RUN edge, the block SHALL load mcand=E_valA, mplier=E_valB, acc=0 and count=0.
REQ-022 Each RUN cycle SHALL add mcand to acc if mplier[0], then shift mcand left 1, shift mplier right 1 (logical) and increment count, all in one edge.
REQ-023 Each RUN cycle SHALL perform exactly one step, with no early termination; mplier==0 SHALL still run all ITER cycles.
REQ-024 Arithmetic SHALL be modulo 2^64: carries out of bit 63 of acc and mcand are discarded.
REQ-025 mul_stall SHALL be combinational: (state==IDLE & start) | (state==RUN & ~abort).
REQ-026 mul_stall SHALL be low in DONE so the pipeline advances on the DONE edge.
REQ-027 Latency: start seen in cycle T; RUN in cycles T+1..T+ITER; DONE in cycle T+ITER+1.
REQ-028 mul_done SHALL be high only in DONE.
REQ-029 mul_valE SHALL be registered and load acc on the RUN->DONE edge; it SHALL hold that value until the next RUN->DONE edge or reset.
REQ-030 mul_cf SHALL load on the same edge with ZF = (product==0), SF = product[63] and OF = 0.
REQ-031 mul_cf SHALL update only on completion; abort or reset SHALL never produce partial flags.
REQ-032 abort in RUN SHALL return the FSM to IDLE next edge, leave mul_valE and mul_cf unchanged and produce no mul_done pulse.
REQ-033 If abort and the final iteration coincide, abort SHALL win: next state is IDLE with no done.
REQ-034 Back-to-back mulq: after DONE->IDLE, a mulq in E SHALL start a new operation with no extra gap (start at T+ITER+2).
REQ-035 Values of E_valA and E_valB SHALL be ignored after the load edge.

Reset
REQ-036 On a rising clk edge with rst_n==0, the block SHALL set state=IDLE, count=0, acc=0, mcand=0, mplier=0, mul_valE=0, mul_cf=3'b000 and mul_done=0.
REQ-037 During reset, mul_stall and mul_busy SHALL be 0 regardless of inputs.
REQ-038 Reset SHALL take priority over start and abort, including mid-RUN; the first start SHALL be accepted no earlier than the first edge with rst_n==1.

Verification
REQ-039 The bench SHALL check: E_icode=6, E_ifun=4, valA=3, valB=5 -> mul_stall high cycles T..T+64, mul_done at T+65, mul_valE=15, mul_cf=3'b000.
REQ-040 The bench SHALL check: valA=0, valB=0x1234 -> mul_valE=0, mul_cf=3'b100 after 65 cycles.
REQ-041 The bench SHALL check: valA=64'hFFFF_FFFF_FFFF_FFFF, valB=2 -> mul_valE=64'hFFFF_FFFF_FFFF_FFFE, mul_cf=3'b010.
REQ-042 The bench SHALL check: abort pulsed at T+30 -> IDLE at T+31, no mul_done, mul_valE/mul_cf keep previous values, mul_stall low from T+30.
REQ-043 The bench SHALL check: rst_n low at T+40 -> all outputs 0 next edge; a following mulq 7*6 completes with mul_valE=42.
REQ-044 The bench SHALL check: two consecutive mulq (2*3 then 4*5) -> done pulses at T+65 and T+131, values 6 then 20, and non-mulq icode in IDLE -> mul_stall stays 0.
